// File: rtl/cache_pkg.sv
// Shared types and constants for the main-memory responder and its cache-side users.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_sram_sp.sv
// Single-port synchronous RAM: one read or write per enabled cycle, registered read, no reset.
module mem_sram_sp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // A write leaves the read register untouched so the last read value stays visible.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory model answering single-word cache read/write requests.
module main_memory_responder
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_DEPTH     = 4096,
    parameter int LATENCY       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_req,
    input  logic                     mem_rd_wr,
    input  logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     mem_ready,
    output logic                     mem_busy,
    output logic                     mem_error
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    mem_state_t             r_state;
    mem_state_t             w_state_next;
    logic [CNT_W-1:0]       r_count;
    logic                   r_rd_wr;
    logic                   r_oor;
    logic [IDX_W-1:0]       r_index;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [DATA_WIDTH-1:0]  w_sram_rdata;
    logic [DATA_WIDTH-1:0]  w_resp_rdata;
    logic                   w_access;
    logic                   w_read_resp;
    logic                   w_unused_addr_bits;

    assign w_unused_addr_bits = ^mem_addr[1:0];

    always_comb begin
        w_state_next = r_state;
        w_access     = 1'b0;
        case (r_state)
            IDLE: if (mem_req) w_state_next = WAIT;
            WAIT: begin
                if (r_count == '0) begin
                    w_state_next = RESP;
                    w_access     = 1'b1;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Requests are only latched in IDLE, so anything arriving while busy is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_rd_wr <= MEM_RD;
            r_oor   <= 1'b0;
            r_index <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && mem_req) begin
                r_count <= CNT_W'(LATENCY - 1);
                r_rd_wr <= mem_rd_wr;
                r_index <= mem_addr[IDX_W+1:2];
                r_wdata <= mem_wdata;
                r_oor   <= |mem_addr[ADDRESS_WIDTH-1:IDX_W+2];
            end else if (r_state == WAIT && r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_read_resp) begin
                r_rdata <= w_resp_rdata;
            end
        end
    end

    // Out-of-range accesses never reach the array.
    mem_sram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .ADDR_BITS  (IDX_W)
    ) u_sram (
        .clk   (clk),
        .en    (w_access && !r_oor),
        .we    (r_rd_wr == MEM_WR),
        .addr  (r_index),
        .wdata (r_wdata),
        .rdata (w_sram_rdata)
    );

    // The RAM's read register has no reset, so the held copy r_rdata drives the port outside RESP.
    assign w_read_resp  = (r_state == RESP) && (r_rd_wr == MEM_RD);
    assign w_resp_rdata = r_oor ? '0 : w_sram_rdata;
    assign mem_rdata    = w_read_resp ? w_resp_rdata : r_rdata;
    assign mem_ready    = (r_state == RESP);
    assign mem_error    = (r_state == RESP) && r_oor;
    assign mem_busy     = (r_state != IDLE);

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32: byte address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 4096: number of words, power of two.
REQ-004 SHALL have parameter LATENCY, default 4: access latency in cycles, legal range 1..15.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port mem_req  input  1  one-cycle request strobe from the cache side.
REQ-008 SHALL have port mem_rd_wr  input  1  0 = read (allocate), 1 = write (writeback/flush).
REQ-009 SHALL have port mem_addr  input  ADDRESS_WIDTH  byte address; bits [1:0] ignored.
REQ-010 SHALL have port mem_wdata  input  DATA_WIDTH  write data, sampled with mem_req.
REQ-011 SHALL have port mem_rdata  output  DATA_WIDTH  read data, valid while mem_ready=1.
REQ-012 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port mem_busy  output  1  high from the cycle after acceptance through the mem_ready cycle.
REQ-014 SHALL have port mem_error  output  1  pulses with mem_ready when the address is out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; mem_busy = (state != IDLE).
REQ-016 In IDLE with mem_req=1: SHALL latch mem_rd_wr, mem_addr, mem_wdata, load counter with LATENCY-1, and go to WAIT.
REQ-017 In WAIT: counter != 0 -> decrement; counter == 0 -> perform the access and go to RESP; WAIT therefore lasts exactly LATENCY cycles.
REQ-018 In RESP: mem_ready=1 for exactly one cycle, then IDLE; a mem_req in the cycle after RESP is accepted.
REQ-019 Latency: request accepted in cycle T -> mem_ready high in cycle T+LATENCY+1.
REQ-020 Word index SHALL be mem_addr[log2(MEM_DEPTH)+1:2]; an address is in range iff mem_addr[ADDRESS_WIDTH-1:log2(MEM_DEPTH)+2] == 0.
REQ-021 Read: mem_rdata SHALL be registered from the array at the access; it holds its value until the next read completes.
REQ-022 Write: the array word SHALL be updated at the access edge; mem_rdata is unchanged.
REQ-023 Out-of-range access: no array write; on a read mem_rdata=0; mem_error=1 together with mem_ready.
REQ-024 mem_req while mem_busy=1 SHALL be dropped, with no state, data, or error effect.
REQ-025 A read after a write to the same address SHALL return the written data (no stale data).

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, counter=0, mem_rdata=0, mem_ready=0, mem_busy=0, mem_error=0.
REQ-027 Array contents SHALL NOT be reset; they are retained across rst.
REQ-028 rst during WAIT SHALL abort the request: an uncommitted write is never performed and no mem_ready is issued.

Structure
REQ-029 Package cache_pkg SHALL hold mem_state_t (IDLE/WAIT/RESP) and constants MEM_RD=1'b0 and MEM_WR=1'b1.
REQ-030 Storage SHALL be a sub-module mem_sram_sp: single-port synchronous RAM, one access per cycle, no reset.
REQ-031 The FSM, counter, and range check SHALL reside in main_memory_responder.

Verification
REQ-032 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> rdata=0xDEADBEEF; mem_ready 5 cycles after each mem_req (LATENCY=4).
REQ-033 Read 0x0000_4000 (out of range at MEM_DEPTH=4096) -> mem_ready=1, mem_error=1, rdata=0; a subsequent read of 0x0 returns the prior value.
REQ-034 mem_req for a write of 0x1111_1111 to 0x20 issued 2 cycles after a read accept -> dropped; a later read of 0x20 returns the old value.
REQ-035 Write 0x5 to 0x8, rst asserted 2 cycles after accept -> no mem_ready; a later read of 0x8 returns the pre-write value.
REQ-036 Back-to-back: new mem_req in the cycle after mem_ready -> accepted; mem_busy shows no IDLE gap beyond that one cycle.
REQ-037 Flush-style burst of 8 writes to 0x0..0x1C, then 8 reads -> all data matches; mem_busy never high in an accept cycle.
